// File: rtl/dsp_alu_arbiter.sv
// Round-robin arbiter sharing one pipelined DSP ALU among num_req requesters.
// Define DSP_ALU_ARBITER_OP_COUNT_EN to build the completed-op counter; otherwise op_count is 0.
module dsp_alu_arbiter #(
    parameter int width   = 32,
    parameter int num_req = 4,
    parameter int lat     = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [num_req-1:0]       req_valid,
    output logic [num_req-1:0]       req_ready,
    input  logic [3*num_req-1:0]     req_op,
    input  logic [width*num_req-1:0] req_a,
    input  logic [width*num_req-1:0] req_b,
    output logic [num_req-1:0]       rsp_valid,
    output logic [width-1:0]         rsp_y,
    output logic                     rsp_err,
    output logic                     idle,
    output logic [31:0]              op_count
);

    localparam int ptr_w = (num_req > 1) ? $clog2(num_req) : 1;

    logic [ptr_w-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ptr_w-1:0]   sel;
    logic               sel_found;
    logic               accept;

    logic               s0_valid_q, s0_valid_d;
    logic [num_req-1:0] s0_tag_q, s0_tag_d;
    logic [2:0]         s0_op_q, s0_op_d;
    logic [width-1:0]   s0_a_q, s0_a_d;
    logic [width-1:0]   s0_b_q, s0_b_d;

    logic [width-1:0]   res_y;
    logic               res_err;

    // Handshake: a request transfers in the cycle req_valid[i] & req_ready[i];
    // req_ready depends only on req_valid, rr_ptr, enable and reset, never on
    // the request payload, and there is no backpressure on the response side.
    always_comb begin
        int idx;
        idx       = 0;
        sel       = rr_ptr_q;
        sel_found = 1'b0;
        for (int k = 0; k < num_req; k++) begin
            idx = (int'(rr_ptr_q) + k) % num_req;
            if (!sel_found && req_valid[idx]) begin
                sel       = ptr_w'(idx);
                sel_found = 1'b1;
            end
        end
    end

    assign accept = sel_found & enable & reset;

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[sel] = 1'b1;
    end

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        s0_valid_d = accept;
        s0_tag_d   = s0_tag_q;
        s0_op_d    = s0_op_q;
        s0_a_d     = s0_a_q;
        s0_b_d     = s0_b_q;
        if (accept) begin
            rr_ptr_d = (int'(sel) == num_req - 1) ? '0 : sel + 1'b1;
            s0_tag_d = req_ready;
            s0_op_d  = req_op[3*int'(sel) +: 3];
            s0_a_d   = req_a[width*int'(sel) +: width];
            s0_b_d   = req_b[width*int'(sel) +: width];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rr_ptr_q   <= '0;
            s0_valid_q <= 1'b0;
            s0_tag_q   <= '0;
            s0_op_q    <= '0;
            s0_a_q     <= '0;
            s0_b_q     <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            s0_valid_q <= s0_valid_d;
            s0_tag_q   <= s0_tag_d;
            s0_op_q    <= s0_op_d;
            s0_a_q     <= s0_a_d;
            s0_b_q     <= s0_b_d;
        end
    end

    // Stage-0 operands only change on accept, so the result holds through bubbles.
    always_comb begin
        res_y   = '0;
        res_err = 1'b0;
        case (s0_op_q)
            3'd0:    res_y = s0_a_q + s0_b_q;
            3'd1:    res_y = s0_a_q - s0_b_q;
            3'd2:    res_y = s0_a_q * s0_b_q;
            3'd3:    res_y = s0_a_q & s0_b_q;
            3'd4:    res_y = s0_a_q | s0_b_q;
            3'd5:    res_y = s0_a_q ^ s0_b_q;
            default: res_err = 1'b1;
        endcase
    end

    generate
        if (lat == 1) begin : g_lat1
            assign rsp_valid = s0_valid_q ? s0_tag_q : '0;
            assign rsp_y     = res_y;
            assign rsp_err   = res_err;
            assign idle      = ~s0_valid_q;
        end else begin : g_latn
            logic [lat-2:0]     pv_q, pv_d;
            logic [num_req-1:0] pt_q [lat-1];
            logic [num_req-1:0] pt_d [lat-1];
            logic [width-1:0]   py_q [lat-1];
            logic [width-1:0]   py_d [lat-1];
            logic [lat-2:0]     pe_q, pe_d;
            logic [lat-2:0]     src_v;
            logic [num_req-1:0] src_t [lat-1];
            logic [width-1:0]   src_y [lat-1];
            logic [lat-2:0]     src_e;

            // Data fields load only behind a valid entry so the last stage holds on bubbles.
            always_comb begin
                src_v[0] = s0_valid_q;
                src_t[0] = s0_tag_q;
                src_y[0] = res_y;
                src_e[0] = res_err;
                for (int k = 1; k < lat - 1; k++) begin
                    src_v[k] = pv_q[k-1];
                    src_t[k] = pt_q[k-1];
                    src_y[k] = py_q[k-1];
                    src_e[k] = pe_q[k-1];
                end
                pv_d = src_v;
                pe_d = pe_q;
                for (int k = 0; k < lat - 1; k++) begin
                    pt_d[k] = pt_q[k];
                    py_d[k] = py_q[k];
                    if (src_v[k]) begin
                        pt_d[k] = src_t[k];
                        py_d[k] = src_y[k];
                        pe_d[k] = src_e[k];
                    end
                end
            end

            always_ff @(posedge clock) begin
                if (!reset) begin
                    pv_q <= '0;
                    pe_q <= '0;
                    for (int k = 0; k < lat - 1; k++) begin
                        pt_q[k] <= '0;
                        py_q[k] <= '0;
                    end
                end else begin
                    pv_q <= pv_d;
                    pe_q <= pe_d;
                    for (int k = 0; k < lat - 1; k++) begin
                        pt_q[k] <= pt_d[k];
                        py_q[k] <= py_d[k];
                    end
                end
            end

            assign rsp_valid = pv_q[lat-2] ? pt_q[lat-2] : '0;
            assign rsp_y     = py_q[lat-2];
            assign rsp_err   = pe_q[lat-2];
            assign idle      = ~s0_valid_q & ~(|pv_q);
        end
    endgenerate

`ifdef DSP_ALU_ARBITER_OP_COUNT_EN
    logic [31:0] op_count_q, op_count_d;

    always_comb begin
        op_count_d = op_count_q;
        if (|rsp_valid) op_count_d = op_count_q + 32'd1;
    end

    always_ff @(posedge clock) begin
        if (!reset) op_count_q <= '0;
        else        op_count_q <= op_count_d;
    end

    assign op_count = op_count_q;
`else
    assign op_count = 32'd0;
`endif

endmodule

// File: tb/tb_dsp_alu_arbiter.sv
// Self-checking bench for dsp_alu_arbiter: vector table, hand sequences and a
// randomized phase scored against a round-robin/ALU reference model.
module tb_dsp_alu_arbiter;

    localparam int W = 32;
    localparam int N = 4;
    localparam int L = 2;

    logic             clock = 1'b0;
    logic             reset;
    logic             enable;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [3*N-1:0]   req_op;
    logic [W*N-1:0]   req_a;
    logic [W*N-1:0]   req_b;
    logic [N-1:0]     rsp_valid;
    logic [W-1:0]     rsp_y;
    logic             rsp_err;
    logic             idle;
    logic [31:0]      op_count;

    dsp_alu_arbiter #(.width(W), .num_req(N), .lat(L)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_y(rsp_y),
        .rsp_err(rsp_err), .idle(idle), .op_count(op_count)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model state; expected queue entry = {due_cycle, tag, err, y}.
    int          m_ptr = 0;
    logic [W-1:0] m_y  = '0;
    logic        m_err = 1'b0;
    int unsigned m_cnt = 0;
    logic [N-1:0] last_rdy = '0;
    logic [68:0] exp_q[$];

    typedef struct {
        int         r;
        logic [2:0] op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        logic       err;
    } vec_t;

    vec_t tab[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [32:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (op)
            3'd0:    return {1'b0, a + b};
            3'd1:    return {1'b0, a - b};
            3'd2:    return {1'b0, p[31:0]};
            3'd3:    return {1'b0, a & b};
            3'd4:    return {1'b0, a | b};
            3'd5:    return {1'b0, a ^ b};
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++)
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    function automatic int unsigned exp_count();
`ifdef DSP_ALU_ARBITER_OP_COUNT_EN
        return m_cnt;
`else
        return 0;
`endif
    endfunction

    // One clock cycle: check at the negedge, advance the model at the posedge.
    task automatic step();
        logic [N-1:0] exp_rdy;
        logic [N-1:0] exp_rv;
        logic [68:0]  e;
        logic [32:0]  r;
        int           s;
        @(negedge clock);
        s = rr_pick(req_valid, m_ptr);
        exp_rdy = '0;
        if (s >= 0 && enable && reset) exp_rdy[s] = 1'b1;
        check("req_ready", req_ready, exp_rdy);
        check("idle", idle, exp_q.size() == 0);
        exp_rv = '0;
        if (exp_q.size() > 0 && exp_q[0][68:37] == cyc) begin
            e      = exp_q.pop_front();
            exp_rv = e[36:33];
            m_err  = e[32];
            m_y    = e[31:0];
        end
        check("rsp_valid", rsp_valid, exp_rv);
        check("rsp_y", rsp_y, m_y);
        check("rsp_err", rsp_err, m_err);
        check("op_count", op_count, exp_count());
        if (exp_rv != 0) m_cnt++;
        last_rdy = exp_rdy;
        @(posedge clock);
        if (!reset) begin
            exp_q.delete();
            m_ptr = 0; m_y = '0; m_err = 1'b0; m_cnt = 0;
        end else if (exp_rdy != 0) begin
            r = alu_ref(req_op[3*s +: 3], req_a[W*s +: W], req_b[W*s +: W]);
            exp_q.push_back({32'(cyc + L), exp_rdy, r});
            m_ptr = (s + 1) % N;
        end
        cyc++;
        #1;
    endtask

    task automatic drive_req(input int i, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        req_op[3*i +: 3] = op;
        req_a[W*i +: W]  = a;
        req_b[W*i +: W]  = b;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    initial begin
        logic [31:0] t3_y[4];
        reset = 1'b0; enable = 1'b1; req_valid = '1;
        req_op = '0; req_a = '0; req_b = '0;

        // Reset held for three edges with every requester valid.
        repeat (3) @(posedge clock);
        #1;
        check("rst_ready", req_ready, 4'b0000);
        check("rst_rsp_valid", rsp_valid, 4'b0000);
        check("rst_idle", idle, 1'b1);
        check("rst_op_count", op_count, 32'd0);
        check("rst_rsp_y", rsp_y, 32'd0);
        reset = 1'b1; req_valid = '0;

        // Single-requester vectors with hand-computed results.
        tab[0] = '{2, 3'd0, 32'hFFFFFFFF, 32'd16,        32'd15,        1'b0};
        tab[1] = '{1, 3'd2, 32'hFFFFFF01, 32'd3,         32'hFFFFFD03,  1'b0};
        tab[2] = '{0, 3'd6, 32'd5,        32'd7,         32'd0,         1'b1};
        tab[3] = '{3, 3'd7, 32'h12345678, 32'h9,         32'd0,         1'b1};
        tab[4] = '{0, 3'd1, 32'd0,        32'd1,         32'hFFFFFFFF,  1'b0};
        tab[5] = '{1, 3'd3, 32'hF0F0F0F0, 32'hFF00FF00,  32'hF000F000,  1'b0};
        tab[6] = '{2, 3'd4, 32'h0F0F0000, 32'h000000F0,  32'h0F0F00F0,  1'b0};
        tab[7] = '{3, 3'd5, 32'hAAAAAAAA, 32'hFFFFFFFF,  32'h55555555,  1'b0};
        tab[8] = '{0, 3'd2, 32'h00010000, 32'h00010000,  32'd0,         1'b0};
        tab[9] = '{1, 3'd0, 32'h7FFFFFFF, 32'd1,         32'h80000000,  1'b0};
        for (int v = 0; v < 10; v++) begin
            drive_req(tab[v].r, tab[v].op, tab[v].a, tab[v].b);
            req_valid = '0;
            req_valid[tab[v].r] = 1'b1;
            #1;
            check("vec_ready", req_ready, 64'(1) << tab[v].r);
            step();
            req_valid = '0;
            step();
            check("vec_rsp_valid", rsp_valid, 64'(1) << tab[v].r);
            check("vec_rsp_y", rsp_y, tab[v].y);
            check("vec_rsp_err", rsp_err, tab[v].err);
            step();
        end

        // All four valid for eight cycles: grants rotate, responses back-to-back.
        apply_reset();
        t3_y[0] = 32'd11; t3_y[1] = 32'd9; t3_y[2] = 32'd10; t3_y[3] = 32'd11;
        drive_req(0, 3'd0, 32'd10, 32'd1);
        drive_req(1, 3'd1, 32'd10, 32'd1);
        drive_req(2, 3'd2, 32'd10, 32'd1);
        drive_req(3, 3'd5, 32'd10, 32'd1);
        for (int k = 0; k < 10; k++) begin
            req_valid = (k < 8) ? 4'b1111 : 4'b0000;
            #1;
            if (k < 8) check("rr_grant", req_ready, 64'(1) << (k % 4));
            if (k >= 2) begin
                check("rr_rsp_valid", rsp_valid, 64'(1) << ((k - 2) % 4));
                check("rr_rsp_y", rsp_y, t3_y[(k - 2) % 4]);
            end
            step();
        end
`ifdef DSP_ALU_ARBITER_OP_COUNT_EN
        check("rr_op_count", op_count, 32'd8);
`else
        check("rr_op_count", op_count, 32'd0);
`endif

        // Two accepts, then enable drops while both requesters stay valid.
        req_valid = 4'b0011;
        step();
        step();
        enable = 1'b0;
        repeat (4) step();
        check("en_idle", idle, 1'b1);
        check("en_ready_blocked", req_ready, 4'b0000);
        enable = 1'b1;
        #1;
        check("en_resume_grant", req_ready, 4'b0001);
        step();
        req_valid = '0;
        repeat (3) step();

        // Accept immediately followed by reset: the op never responds.
        req_valid = 4'b1000;
        drive_req(3, 3'd0, 32'd1, 32'd2);
        step();
        reset = 1'b0;
        req_valid = '0;
        step();
        reset = 1'b1;
        req_valid = 4'b1010;
        #1;
        check("rst_kill_rsp", rsp_valid, 4'b0000);
        check("rst_kill_idle", idle, 1'b1);
        check("rst_ptr_grant", req_ready, 4'b0010);
        step();

        // Randomized traffic; pending requests hold their payload until granted.
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && !last_rdy[i]) begin
                    if ($urandom_range(0, 7) == 0) req_valid[i] = 1'b0;
                end else begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    drive_req(i, 3'($urandom_range(0, 7)), $urandom, $urandom);
                end
            end
            enable = ($urandom_range(0, 9) != 0);
            reset  = ($urandom_range(0, 59) != 0);
            step();
        end
        reset = 1'b1; enable = 1'b1; req_valid = '0;
        repeat (L + 2) step();
        check("drain_idle", idle, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dsp_alu_arbiter.md
Name: dsp_alu_arbiter

Overview:
- Shares one pipelined DSP ALU between N requesters. The ALU supports add, sub, mul, and, or and xor.
- Arbitration is round-robin with a valid/ready request handshake.
- Issues at most one operation per cycle.
- Returns each result after a fixed latency, tagged one-hot to the requester that issued it.
- Sits between the scalar compute clients and the DSP primitive layer.

Parameters:
- width, 32, operand and result width in bits (1..48)
- num_req, 4, number of requesters (2..8)
- lat, 2, ALU pipeline depth in cycles from accept to result (1..4)

Ports:
- clock  input  1  clock
- reset  input  1  synchronous, active-low reset
- enable  input  1  when low, no new grants; in-flight ops still complete
- req_valid  input  num_req  per-requester request valid
- req_ready  output  num_req  per-requester grant; at most one bit high
- req_op  input  3*num_req  opcode per requester, slot i = bits [3i+2:3i]
- req_a  input  width*num_req  operand a per requester
- req_b  input  width*num_req  operand b per requester
- rsp_valid  output  num_req  one-hot result valid, no backpressure
- rsp_y  output  width  result, shared by all requesters
- rsp_err  output  1  reserved opcode flag, qualified by rsp_valid
- idle  output  1  high when no op is in flight
- op_count  output  32  completed-op counter (see Optional Feature)

Behaviour:
- Reset: reset is synchronous, active-low; clock is clock. When reset=0 at a posedge:
  - pipeline valid bits cleared, rr_ptr=0, op_count=0
  - rsp_valid=0, rsp_y=0, rsp_err=0, idle=1
  - in-flight ops are discarded and never produce rsp_valid
  - req_ready is forced to 0 while reset=0.
- Arbitration (combinational from req_valid and rr_ptr):
  - Selected index = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, … modulo num_req.
  - req_ready[sel]=1 only if enable=1 and reset=1. All other ready bits are 0.
  - Accept = req_valid[sel] & req_ready[sel].
- Pointer update: on accept, rr_ptr <= (sel+1) mod num_req. Otherwise rr_ptr holds.
- Requester rule: a requester must hold its op, a and b stable while valid and not ready. Dropping valid without a grant is allowed; the arbiter keeps no memory of it.
- Opcodes:
  - 0 add: a+b
  - 1 sub: a−b
  - 2 mul: low width bits of a*b (two's complement, so signedness is irrelevant)
  - 3 and, 4 or, 5 xor
  - 6, 7 reserved: y=0, err=1
  - All arithmetic is modulo 2^width.
- Pipeline:
  - Stage 0 registers op, a, b and the one-hot tag on accept.
  - The result is computed and carried through lat stages.
  - An op accepted at cycle t gives rsp_valid=tag, rsp_y, rsp_err at cycle t+lat for exactly 1 cycle.
  - Throughput is 1 op/cycle. Back-to-back accepts give back-to-back responses in accept order.
- Bubbles: in any cycle with no response, rsp_valid=0 and rsp_y/rsp_err hold their last value.
- idle: 1 iff every pipeline valid bit is 0. It does not depend on the current-cycle accept.
- enable:
  - Dropping enable mid-stream blocks new grants from that same cycle.
  - Ops already in flight still complete at their scheduled cycles.
  - rr_ptr holds while enable=0.
- Simultaneous events:
  - A response and a new accept in the same cycle are independent.
  - Reset wins over everything.
- Fairness: with every requester continuously valid, grants rotate 0,1,…,num_req−1,0, … and no requester waits more than num_req−1 accepts.

Optional Feature:
- Macro DSP_ALU_ARBITER_OP_COUNT_EN.
- Defined: op_count increments by 1 in each cycle rsp_valid≠0, wraps at 2^32, and clears on reset.
- Undefined: op_count is tied to 32'd0 and no counter register is built.
- Port list is the same in both builds.

Test Plan:
1. Reset held low 3 cycles while all req_valid=1 → req_ready=0, rsp_valid=0, idle=1, op_count=0.
2. Only req 2 valid: op=0, a=8'hFF-style −1 (32'hFFFFFFFF), b=16. lat=2 → req_ready=4'b0100 at t, then at t+2 rsp_valid=4'b0100, rsp_y=15, rsp_err=0.
3. All 4 requesters valid for 8 cycles with ops add/sub/mul/xor (a=10, b=1 for each) → grant order 0,1,2,3,0,1,2,3. Responses in the same order with y=11, 9, 10, 11. 8 consecutive rsp_valid cycles; op_count=8 when the macro is defined.
4. Req 1 op=2, a=−255, b=3 → rsp_y=32'hFFFFFD03 (−765). Req 0 op=6 → rsp_y=0, rsp_err=1.
5. Two ops accepted, then enable=0 → no further req_ready. Both responses still arrive at t+2 and t+3, then idle=1. When enable returns to 1, arbitration resumes from rr_ptr.
6. Accept at t, reset=0 at t+1 → no rsp_valid at t+2, idle=1, and rr_ptr=0 afterwards (next grant goes to the lowest valid index).
